// File: rtl/esc_pwm_pkg.sv
// Shared constants and sizing helpers for the ESC PWM transmitter; timing defaults
// match the pulse-width receiver so the two blocks round-trip the same N_VAL values.
package esc_pwm_pkg;

  localparam int N_MOTORS            = 4;
  localparam int DEF_CLK_HZ          = 38_000_000;
  localparam int DEF_N_VAL           = 14;
  localparam int DEF_PERIOD_US       = 2500;
  localparam int DEF_MIN_US          = 1000;
  localparam int DEF_MAX_US          = 2000;
  localparam int DEF_FAILSAFE_FRAMES = 10;

  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

  // One spare bit so MIN_US + span never wraps before saturation is applied.
  function automatic int frame_width(input int period_us);
    return $clog2(period_us) + 1;
  endfunction

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/esc_pwm_channel.sv
// One ESC output: pending command, frame-aligned active width with saturation,
// and the registered frame_us < active comparator.
module esc_pwm_channel
  import esc_pwm_pkg::*;
#(
  parameter int N_VAL  = DEF_N_VAL,
  parameter int FW     = frame_width(DEF_PERIOD_US),
  parameter int MIN_US = DEF_MIN_US,
  parameter int MAX_US = DEF_MAX_US
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update_i,
  input  logic [N_VAL-1:0] val_i,
  input  logic             load_i,
  input  logic             arm_i,
  input  logic [FW-1:0]    frame_us_i,
  output logic             pwm_o
);

  localparam int SPAN = MAX_US - MIN_US;

  logic [N_VAL-1:0] pend_q, pend_d, src;
  logic [FW-1:0]    active_q, active_d, width_sat;
  logic             pwm_q, pwm_d;

  always_comb begin
    // A strobe landing on the boundary cycle bypasses pending for this load.
    src    = update_i ? val_i : pend_q;
    pend_d = src;
    if (32'(src) >= SPAN) width_sat = FW'(MAX_US);
    else                  width_sat = FW'(MIN_US) + FW'(src);
    active_d = active_q;
    if (load_i) active_d = arm_i ? width_sat : FW'(MIN_US);
    pwm_d = (frame_us_i < active_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q   <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/esc_pwm_transmitter.sv
// Four-channel ESC servo PWM generator sharing one microsecond timebase and frame.
// Define PWM_FAILSAFE_EN to build the no-update watchdog that forces MIN_US pulses.
module esc_pwm_transmitter
  import esc_pwm_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int N_VAL           = DEF_N_VAL,
  parameter int PERIOD_US       = DEF_PERIOD_US,
  parameter int MIN_US          = DEF_MIN_US,
  parameter int MAX_US          = DEF_MAX_US,
  parameter int FAILSAFE_FRAMES = DEF_FAILSAFE_FRAMES
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             update,
  input  logic             armed,
  input  logic [N_VAL-1:0] motor_1_val,
  input  logic [N_VAL-1:0] motor_2_val,
  input  logic [N_VAL-1:0] motor_3_val,
  input  logic [N_VAL-1:0] motor_4_val,
  output logic             motor_1_pwm,
  output logic             motor_2_pwm,
  output logic             motor_3_pwm,
  output logic             motor_4_pwm,
  output logic             frame_start,
  output logic             failsafe
);

  localparam int US_DIV = us_div(CLK_HZ);
  localparam int PW     = presc_width(US_DIV);
  localparam int FW     = frame_width(PERIOD_US);
  localparam logic [PW-1:0] PRESC_LAST = PW'(US_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(PERIOD_US - 1);

  if ((CLK_HZ < 1_000_000) || ((CLK_HZ % 1_000_000) != 0)) begin : g_bad_clk
    $error("esc_pwm_transmitter: CLK_HZ must be a positive multiple of 1 MHz");
  end
  if (!((MIN_US < MAX_US) && (MAX_US < PERIOD_US))) begin : g_bad_timing
    $error("esc_pwm_transmitter: need MIN_US < MAX_US < PERIOD_US");
  end
  if (FAILSAFE_FRAMES < 1) begin : g_bad_fs
    $error("esc_pwm_transmitter: FAILSAFE_FRAMES must be at least 1");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] frame_us_q, frame_us_d;
  logic          us_tick, frame_boundary, chan_arm;

  always_comb begin
    us_tick        = (presc_q == PRESC_LAST);
    frame_boundary = us_tick && (frame_us_q == FRAME_LAST);
    presc_d        = us_tick ? '0 : presc_q + 1'b1;
    frame_us_d     = frame_us_q;
    if (us_tick) frame_us_d = frame_boundary ? '0 : frame_us_q + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      frame_us_q <= '0;
    end else begin
      presc_q    <= presc_d;
      frame_us_q <= frame_us_d;
    end
  end

  assign frame_start = frame_boundary;

`ifdef PWM_FAILSAFE_EN
  localparam int FSW = $clog2(FAILSAFE_FRAMES + 1);
  localparam logic [FSW-1:0] FS_TRIP_AT = FSW'(FAILSAFE_FRAMES - 1);
  localparam logic [FSW-1:0] FS_SAT     = FSW'(FAILSAFE_FRAMES);

  logic [FSW-1:0] fs_cnt_q, fs_cnt_d;
  logic           failsafe_q, failsafe_d, fs_trip;

  // The count saturates once tripped, so every later boundary keeps loading MIN_US.
  always_comb begin
    fs_cnt_d   = fs_cnt_q;
    failsafe_d = failsafe_q;
    fs_trip    = 1'b0;
    if (update) begin
      fs_cnt_d   = '0;
      failsafe_d = 1'b0;
    end else if (frame_boundary) begin
      if (fs_cnt_q >= FS_TRIP_AT) begin
        fs_trip    = 1'b1;
        failsafe_d = 1'b1;
        fs_cnt_d   = FS_SAT;
      end else begin
        fs_cnt_d = fs_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      fs_cnt_q   <= '0;
      failsafe_q <= 1'b0;
    end else begin
      fs_cnt_q   <= fs_cnt_d;
      failsafe_q <= failsafe_d;
    end
  end

  assign chan_arm = armed & ~fs_trip;
  assign failsafe = failsafe_q;
`else
  assign chan_arm = armed;
  assign failsafe = 1'b0;
`endif

  // update is a single-cycle strobe with no back-pressure: every asserted cycle
  // overwrites all four pending commands.
  logic [N_VAL-1:0]    motor_val [N_MOTORS];
  logic [N_MOTORS-1:0] motor_pwm;

  assign motor_val[0] = motor_1_val;
  assign motor_val[1] = motor_2_val;
  assign motor_val[2] = motor_3_val;
  assign motor_val[3] = motor_4_val;

  for (genvar i = 0; i < N_MOTORS; i++) begin : g_chan
    esc_pwm_channel #(
      .N_VAL (N_VAL),
      .FW    (FW),
      .MIN_US(MIN_US),
      .MAX_US(MAX_US)
    ) u_chan (
      .clk       (sys_clk),
      .rst       (reset),
      .update_i  (update),
      .val_i     (motor_val[i]),
      .load_i    (frame_boundary),
      .arm_i     (chan_arm),
      .frame_us_i(frame_us_q),
      .pwm_o     (motor_pwm[i])
    );
  end

  assign motor_1_pwm = motor_pwm[0];
  assign motor_2_pwm = motor_pwm[1];
  assign motor_3_pwm = motor_pwm[2];
  assign motor_4_pwm = motor_pwm[3];

endmodule

// File: tb/tb_esc_pwm_transmitter.sv
// Directed bench for esc_pwm_transmitter at a scaled timebase (2 MHz clock, 250 us frame,
// 100..200 us pulses) so every scenario fits in a few dozen short frames.
module tb_esc_pwm_transmitter;

  localparam int CLK_HZ    = 2_000_000;
  localparam int N_VAL     = 14;
  localparam int PERIOD_US = 250;
  localparam int MIN_US    = 100;
  localparam int MAX_US    = 200;
  localparam int FS_FRAMES = 10;
  localparam int DIV       = CLK_HZ / 1_000_000;
  localparam int FRAME     = PERIOD_US * DIV;
`ifdef PWM_FAILSAFE_EN
  localparam bit FS_EN = 1'b1;
`else
  localparam bit FS_EN = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic update  = 1'b0;
  logic armed   = 1'b0;
  logic [N_VAL-1:0] m1_val = '0, m2_val = '0, m3_val = '0, m4_val = '0;
  logic m1_pwm, m2_pwm, m3_pwm, m4_pwm, frame_start, failsafe;
  logic [3:0] pwm_all;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_w[4];
  int last_w[4];
  int len_cnt  = 0;
  int last_len = 0;
  int n_frames = 0;
  event frame_ev;

  // ---------------- clock / DUT ----------------
  always #5 sys_clk = ~sys_clk;

  esc_pwm_transmitter #(
    .CLK_HZ         (CLK_HZ),
    .N_VAL          (N_VAL),
    .PERIOD_US      (PERIOD_US),
    .MIN_US         (MIN_US),
    .MAX_US         (MAX_US),
    .FAILSAFE_FRAMES(FS_FRAMES)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .update     (update),
    .armed      (armed),
    .motor_1_val(m1_val),
    .motor_2_val(m2_val),
    .motor_3_val(m3_val),
    .motor_4_val(m4_val),
    .motor_1_pwm(m1_pwm),
    .motor_2_pwm(m2_pwm),
    .motor_3_pwm(m3_pwm),
    .motor_4_pwm(m4_pwm),
    .frame_start(frame_start),
    .failsafe   (failsafe)
  );

  assign pwm_all = {m4_pwm, m3_pwm, m2_pwm, m1_pwm};

  // ---------------- frame monitor ----------------
  // Each window runs from the cycle after one frame_start up to and including the next.
  initial begin
    for (int k = 0; k < 4; k++) cnt_w[k] = 0;
    forever begin
      @(negedge sys_clk);
      if (reset) begin
        for (int k = 0; k < 4; k++) cnt_w[k] = 0;
        len_cnt = 0;
      end else begin
        for (int k = 0; k < 4; k++) cnt_w[k] += int'(pwm_all[k]);
        len_cnt++;
        if (frame_start) begin
          for (int k = 0; k < 4; k++) begin
            last_w[k] = cnt_w[k];
            cnt_w[k]  = 0;
          end
          last_len = len_cnt;
          len_cnt  = 0;
          n_frames++;
          -> frame_ev;
        end
      end
    end
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_frame();
    int start;
    start = n_frames;
    fork
      begin @(frame_ev); end
      begin repeat (2 * FRAME) @(negedge sys_clk); end
    join_any
    disable fork;
    check("frame_seen", n_frames - start, 1);
  endtask

  task automatic check_frame(input string tag, input int w1, input int w2, input int w3,
                             input int w4);
    check($sformatf("%s_len", tag), last_len, FRAME);
    check($sformatf("%s_m1", tag), last_w[0], w1);
    check($sformatf("%s_m2", tag), last_w[1], w2);
    check($sformatf("%s_m3", tag), last_w[2], w3);
    check($sformatf("%s_m4", tag), last_w[3], w4);
  endtask

  task automatic pulse_update();
    @(negedge sys_clk);
    update = 1'b1;
    @(negedge sys_clk);
    update = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge sys_clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  // Expected widths in cycles = (MIN_US + min(val, 100)) * DIV.
  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_m1", m1_pwm, 0);
    check("rst_m2", m2_pwm, 0);
    check("rst_m3", m3_pwm, 0);
    check("rst_m4", m4_pwm, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_failsafe", failsafe, 0);

    release_reset();
    armed  = 1'b1;
    m1_val = 14'd50;
    m2_val = 14'd0;
    m3_val = 14'd16383;
    m4_val = 14'd30;
    pulse_update();
    wait_frame(); check_frame("f0_first", 0, 0, 0, 0);
    wait_frame(); check_frame("f1_cmd", 300, 200, 400, 260);

    @(negedge sys_clk);
    armed  = 1'b0;
    m4_val = 14'd80;
    pulse_update();
    wait_frame(); check_frame("f2_hold", 300, 200, 400, 260);
    wait_frame(); check_frame("f3_disarmed", 200, 200, 200, 200);
    @(negedge sys_clk);
    armed = 1'b1;
    wait_frame(); check_frame("f4_arm_midframe", 200, 200, 200, 200);
    wait_frame(); check_frame("f5_rearmed", 300, 200, 400, 360);

    // wait_frame returns inside the boundary cycle, so this strobe lands on the boundary edge
    m1_val = 14'd20;
    update = 1'b1;
    @(negedge sys_clk);
    update = 1'b0;
    repeat (100) @(negedge sys_clk);
    m1_val = 14'd70;
    pulse_update();
    wait_frame(); check_frame("f6_bypass", 240, 200, 400, 360);
    wait_frame(); check_frame("f7_midframe_upd", 340, 200, 400, 360);
    check("no_failsafe_normal", failsafe, 0);

    repeat (20) @(negedge sys_clk);
    check("pre_reset_m1_high", m1_pwm, 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_m1", m1_pwm, 0);
    check("async_rst_m2", m2_pwm, 0);
    check("async_rst_m3", m3_pwm, 0);
    check("async_rst_m4", m4_pwm, 0);
    check("async_rst_frame_start", frame_start, 0);
    repeat (2) @(negedge sys_clk);
    release_reset();
    wait_frame(); check_frame("r0_after_reset", 0, 0, 0, 0);
    wait_frame(); check_frame("r1_pending_cleared", 200, 200, 200, 200);

    // Watchdog: commanded widths for FS_FRAMES-1 loads, then MIN_US when enabled.
    @(negedge sys_clk);
    m1_val = 14'd50;
    m2_val = 14'd0;
    m3_val = 14'd16383;
    m4_val = 14'd30;
    pulse_update();
    wait_frame(); check_frame("w_pre", 200, 200, 200, 200);
    for (int j = 2; j <= FS_FRAMES; j++) begin
      wait_frame();
      check_frame($sformatf("w_cmd%0d", j), 300, 200, 400, 260);
      check($sformatf("w_fs_low%0d", j), failsafe, 0);
    end
    wait_frame();
    check_frame("w_tripped", FS_EN ? 200 : 300, 200, FS_EN ? 200 : 400, FS_EN ? 200 : 260);
    check("w_failsafe_set", failsafe, FS_EN);
    @(negedge sys_clk);
    m1_val = 14'd20;
    pulse_update();
    check("w_failsafe_cleared", failsafe, 0);
    wait_frame();
    check_frame("w_still_min", FS_EN ? 200 : 300, 200, FS_EN ? 200 : 400, FS_EN ? 200 : 260);
    wait_frame(); check_frame("w_resumed", 240, 200, 400, 260);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
